// File: rtl/bus_div_pkg.sv
// bus_div_pkg: shared state encoding and default widths for the bus divider.
package bus_div_pkg;
    typedef enum logic [1:0] {LOAD, DIVIDE, UNLOAD} state_e;
    localparam int BUS_W_DEF  = 8;
    localparam int DATA_W_DEF = 16;
endpackage

// File: rtl/bus_div_accel_if.sv
// bus_div_accel_if: beat-stream handshake and status signals of the divider.
interface bus_div_accel_if import bus_div_pkg::*; #(
    parameter int BUS_W = BUS_W_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [BUS_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [BUS_W-1:0] out_data;
    logic             busy;
    logic             div_by_zero;
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, div_by_zero
    );
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, div_by_zero
    );
endinterface

// File: rtl/restoring_div_core.sv
// restoring_div_core: unsigned restoring divider, one quotient bit per cycle.
module restoring_div_core #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] q_o,
    output logic [DATA_W-1:0] r_o,
    output logic              done_o
);
    localparam int SW = $clog2(DATA_W + 1);
    logic [DATA_W-1:0] rem_q, quo_q, b_q;
    logic [SW-1:0]     step_q;
    logic              run_q, done_q;
    logic [DATA_W:0]   rem_sh, diff;
    // quo_q doubles as the dividend shift register, freeing one bit per step
    assign rem_sh = {rem_q, quo_q[DATA_W-1]};
    assign diff   = rem_sh - {1'b0, b_q};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            b_q    <= '0;
            step_q <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= run_q && step_q == SW'(DATA_W - 1);
            if (start_i) begin
                rem_q  <= '0;
                quo_q  <= a_i;
                b_q    <= b_i;
                step_q <= '0;
                run_q  <= 1'b1;
            end else if (run_q) begin
                rem_q  <= diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
                quo_q  <= {quo_q[DATA_W-2:0], ~diff[DATA_W]};
                step_q <= step_q + SW'(1);
                run_q  <= step_q != SW'(DATA_W - 1);
            end
        end
    end
    assign q_o    = quo_q;
    assign r_o    = rem_q;
    assign done_o = done_q;
endmodule

// File: rtl/bus_div_accel.sv
// bus_div_accel: collects A/B beats, divides, then streams Q/R beats out.
module bus_div_accel import bus_div_pkg::*; #(
    parameter int BUS_W  = BUS_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    bus_div_accel_if.slave     bus
);
    localparam int NB = DATA_W / BUS_W;
    localparam int CW = $clog2(2 * NB);
    localparam int FW = 2 * DATA_W;
    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [FW-BUS_W-1:0]   in_sr_q, in_sr_d;
    logic [FW-1:0]         res_q, res_d, frame;
    logic                  dbz_q, dbz_d, start, done, last;
    logic [DATA_W-1:0]     q, r;
    // frame already includes the beat on the bus so the core starts on the last edge
    assign frame = {in_sr_q, bus.in_data};
    assign last  = cnt_q == CW'(2 * NB - 1);
    restoring_div_core #(.DATA_W(DATA_W)) u_core (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .a_i     (frame[FW-1:DATA_W]),
        .b_i     (frame[DATA_W-1:0]),
        .q_o     (q),
        .r_o     (r),
        .done_o  (done)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        in_sr_d = in_sr_q;
        res_d   = res_q;
        dbz_d   = dbz_q;
        start   = 1'b0;
        unique case (state_q)
            LOAD: if (bus.in_valid) begin
                in_sr_d = frame[FW-BUS_W-1:0];
                cnt_d   = last ? '0 : cnt_q + CW'(1);
                if (last) begin
                    state_d = DIVIDE;
                    start   = 1'b1;
                    dbz_d   = frame[DATA_W-1:0] == '0;
                end
            end
            DIVIDE: if (done) begin
                state_d = UNLOAD;
                res_d   = {q, r};
            end
            UNLOAD: if (bus.out_ready) begin
                res_d   = res_q << BUS_W;
                cnt_d   = last ? '0 : cnt_q + CW'(1);
                state_d = last ? LOAD : UNLOAD;
            end
            default: state_d = LOAD;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            in_sr_q <= '0;
            res_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            in_sr_q <= in_sr_d;
            res_q   <= res_d;
            dbz_q   <= dbz_d;
        end
    end
    assign bus.in_ready    = state_q == LOAD;
    assign bus.out_valid   = state_q == UNLOAD;
    assign bus.out_data    = res_q[FW-1 -: BUS_W];
    assign bus.busy        = !(state_q == LOAD && cnt_q == '0);
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_bus_div_accel.sv
// tb_bus_div_accel: directed checks of the beat-serial divider at 16 and 32 bits.
module tb_bus_div_accel;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    always #5 clk = ~clk;
    bus_div_accel_if #(.BUS_W(8)) bi ();
    bus_div_accel_if #(.BUS_W(8)) bi32 ();
    bus_div_accel #(.BUS_W(8), .DATA_W(16)) dut (.clk(clk), .rst(rst), .bus(bi.slave));
    bus_div_accel #(.BUS_W(8), .DATA_W(32)) dut32 (.clk(clk), .rst(rst), .bus(bi32.slave));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic send_frame(input logic [31:0] f, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            if (gaps) wait_cyc($urandom_range(0, 3));
            bi.in_valid = 1'b1;
            bi.in_data  = f[31-8*i -: 8];
            check("in_ready load", 32'(bi.in_ready), 32'd1);
            wait_cyc(1);
            bi.in_valid = 1'b0;
        end
    endtask
    task automatic wait_out(input int lat);
        int k = 0;
        while (!bi.out_valid && k < 200) begin
            wait_cyc(1);
            k++;
        end
        check("latency", 32'(k), 32'(lat));
    endtask
    task automatic recv_frame(input logic [31:0] e, input int stall);
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < stall; s++) begin
                check("hold data", 32'(bi.out_data), 32'(e[31-8*i -: 8]));
                check("hold valid", 32'(bi.out_valid), 32'd1);
                wait_cyc(1);
            end
            bi.out_ready = 1'b1;
            check("out beat", 32'(bi.out_data), 32'(e[31-8*i -: 8]));
            check("out_valid", 32'(bi.out_valid), 32'd1);
            wait_cyc(1);
            bi.out_ready = 1'b0;
        end
        check("frame end valid", 32'(bi.out_valid), 32'd0);
        check("frame end ready", 32'(bi.in_ready), 32'd1);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [63:0] f32, e32;
        int k;
        bi.in_valid = 0; bi.in_data = 0; bi.out_ready = 0;
        bi32.in_valid = 0; bi32.in_data = 0; bi32.out_ready = 0;
        wait_cyc(2);
        check("rst in_ready", 32'(bi.in_ready), 32'd1);
        check("rst out_valid", 32'(bi.out_valid), 32'd0);
        check("rst out_data", 32'(bi.out_data), 32'd0);
        check("rst busy", 32'(bi.busy), 32'd0);
        check("rst dbz", 32'(bi.div_by_zero), 32'd0);
        rst = 1'b0;
        // 100 / 7
        send_frame(32'h0064_0007, 1'b0);
        check("busy divide", 32'(bi.busy), 32'd1);
        check("in_ready divide", 32'(bi.in_ready), 32'd0);
        wait_out(17);
        check("dbz 100/7", 32'(bi.div_by_zero), 32'd0);
        recv_frame(32'h000E_0002, 0);
        // divide by zero
        send_frame(32'h1234_0000, 1'b0);
        wait_out(17);
        check("dbz x/0", 32'(bi.div_by_zero), 32'd1);
        recv_frame(32'hFFFF_1234, 0);
        // consumer back-pressure
        send_frame(32'h00FF_0010, 1'b0);
        wait_out(17);
        check("dbz 255/16", 32'(bi.div_by_zero), 32'd0);
        recv_frame(32'h000F_000F, 5);
        // asynchronous reset mid-DIVIDE
        send_frame(32'h0064_0007, 1'b0);
        wait_cyc(8);
        rst = 1'b1;
        #1;
        check("arst out_valid", 32'(bi.out_valid), 32'd0);
        check("arst busy", 32'(bi.busy), 32'd0);
        check("arst in_ready", 32'(bi.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(32'h0009_0003, 1'b0);
        wait_out(17);
        recv_frame(32'h0003_0000, 0);
        // gapped input, in_valid held while dividing
        send_frame(32'h1234_0056, 1'b1);
        bi.in_valid = 1'b1;
        bi.in_data  = 8'hAA;
        wait_cyc(3);
        check("ignored in_valid", 32'(bi.in_ready), 32'd0);
        wait_out(14);
        bi.in_valid = 1'b0;
        recv_frame(32'h0036_0010, 1);
        check("no extra beat", 32'(bi.busy), 32'd0);
        // 32-bit instance
        f32 = 64'hFFFF_FFFF_0000_0010;
        e32 = 64'h0FFF_FFFF_0000_000F;
        for (int i = 0; i < 8; i++) begin
            bi32.in_valid = 1'b1;
            bi32.in_data  = f32[63-8*i -: 8];
            wait_cyc(1);
        end
        bi32.in_valid = 1'b0;
        k = 0;
        while (!bi32.out_valid && k < 200) begin
            wait_cyc(1);
            k++;
        end
        check("latency 32", 32'(k), 32'd33);
        for (int i = 0; i < 8; i++) begin
            bi32.out_ready = 1'b1;
            check("out beat 32", 32'(bi32.out_data), 32'(e32[63-8*i -: 8]));
            wait_cyc(1);
        end
        bi32.out_ready = 1'b0;
        check("frame end 32", 32'(bi32.out_valid), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_div_accel.md
BUS_DIV_ACCEL -- requirements
Module: bus_div_accel

Interface
REQ-001 SHALL have parameter BUS_W, default 8: bus beat width in bits.
REQ-002 SHALL have parameter DATA_W, default 16: operand width in bits, integer multiple of BUS_W, >= BUS_W; NB = DATA_W/BUS_W beats per operand.
REQ-003 Ports SHALL be (name direction width meaning):
- clk  in  1  clock; reset rst, asynchronous, active-high; clock clk.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input beat offered.
- in_ready  out  1  block accepts input beat.
- in_data  in  BUS_W  input beat.
- out_valid  out  1  output beat offered.
- out_ready  in  1  consumer accepts output beat.
- out_data  out  BUS_W  output beat.
- busy  out  1  high in any state other than LOAD with beat count 0.
- div_by_zero  out  1  divisor of current result was 0; valid while out_valid.

Function
REQ-004 A beat SHALL transfer on a rising clk edge where valid and ready are both high; no other edge transfers.
REQ-005 Input frame SHALL be 2*NB beats: dividend A MSB-beat first, then divisor B MSB-beat first.
REQ-006 Output frame SHALL be 2*NB beats: quotient Q MSB-beat first, then remainder R MSB-beat first.
REQ-007 FSM SHALL have states LOAD, DIVIDE, UNLOAD; reset state LOAD.
REQ-008 LOAD: in_ready=1, out_valid=0; beat counter increments per accepted beat; accepting beat 2*NB-1 SHALL move to DIVIDE and clear the counter.
REQ-009 Idle cycles (in_valid=0) between input beats SHALL be allowed without losing collected beats.
REQ-010 DIVIDE: in_ready=0, out_valid=0; unsigned restoring division, one quotient bit per cycle, exactly DATA_W cycles.
REQ-011 Restoring step SHALL use a DATA_W+1-bit partial remainder: shift in next dividend bit, subtract B, keep result and set quotient bit 1 if non-negative, else restore and set bit 0.
REQ-012 Latency: last input beat accepted at edge t SHALL give out_valid=1 with the first Q beat from edge t+DATA_W+1.
REQ-013 B=0 SHALL not be special-cased in arithmetic: result SHALL be Q=all ones, R=A; div_by_zero SHALL be 1.
REQ-014 UNLOAD: out_valid=1, in_ready=0; out_data = beat indexed by counter; counter advances only on accepted beat; out_data stable while out_valid=1 and out_ready=0.
REQ-015 Acceptance of output beat 2*NB-1 SHALL return to LOAD with counter 0; in_ready SHALL be 1 on the following cycle, so back-to-back frames are allowed.
REQ-016 in_valid while in_ready=0 SHALL be ignored and cause no state change.
REQ-017 div_by_zero SHALL be registered at DIVIDE entry and held until the next DIVIDE entry.

Reset
REQ-018 rst SHALL asynchronously force LOAD, all counters 0, operand/result registers 0, in_ready=1, out_valid=0, out_data=0, busy=0, div_by_zero=0.
REQ-019 rst asserted mid-LOAD, mid-DIVIDE or mid-UNLOAD SHALL discard the partial frame; first edge after release SHALL accept beat 0 of a new frame.

Structure
REQ-020 Package bus_div_pkg SHALL hold the state enum (LOAD, DIVIDE, UNLOAD) and default BUS_W/DATA_W constants.
REQ-021 Division SHALL sit in sub-module restoring_div_core (DATA_W param; start, A, B in; Q, R, done out); done SHALL pulse one cycle after the DATA_W-th step.
REQ-022 Beat counter width SHALL be $clog2(2*NB); wrapper SHALL hold input and output shift or indexed registers.

Verification
REQ-023 DATA_W=16: beats 00,64,00,07 -> after 17 cycles beats 00,0E,00,02; div_by_zero=0.
REQ-024 Beats 12,34,00,00 -> beats FF,FF,12,34; div_by_zero=1.
REQ-025 A=0x00FF, B=0x0010, out_ready low 5 cycles per beat -> out_data holds each beat; sequence 00,0F,00,0F; no beat lost or duplicated.
REQ-026 rst pulsed 8 cycles into DIVIDE -> out_valid=0; new frame 00,09,00,03 -> 00,03,00,00.
REQ-027 Input beats with random 0-3 cycle gaps and in_valid held during DIVIDE -> correct result; extra beats not consumed.
REQ-028 DATA_W=32: A=0xFFFFFFFF, B=0x00000010 -> Q=0x0FFFFFFF, R=0x0000000F; first Q beat 33 cycles after last input beat.
